// File: rtl/fpu_to_int.sv
// Float-to-integer read-out stage: converts {sign, exp[9:0], mant[20:0]} to a signed
// 32-bit integer truncated toward zero, aligning the mantissa one bit per cycle.
module fpu_to_int #(
   parameter int EXP_BIAS = 511
) (
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] int_out,
   output logic [1:0]  status_out
);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SIGN, DONE} state_t;

   localparam logic [1:0] ST_OVERFLOW  = 2'd0;
   localparam logic [1:0] ST_UNDERFLOW = 2'd1;
   localparam logic [1:0] ST_EXACT     = 2'd2;
   localparam logic [1:0] ST_INEXACT   = 2'd3;

   state_t      state_q, state_d;
   logic [31:0] op_q, op_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        sticky_q, sticky_d;
   logic [31:0] int_q, int_d;
   logic [1:0]  status_q, status_d;

   logic               opSign;
   logic [9:0]         opExp;
   logic [20:0]        opMant;
   logic signed [10:0] e;
   logic signed [10:0] eMinus21;
   logic signed [10:0] eMinus21Neg;
   logic [4:0]         shiftCount;
   logic [31:0]        satValue;

   assign opSign      = op_q[31];
   assign opExp       = op_q[30:21];
   assign opMant      = op_q[20:0];
   assign e           = 11'({1'b0, opExp}) - 11'(EXP_BIAS);
   assign eMinus21    = e - 11'sd21;
   assign eMinus21Neg = 11'sd0 - eMinus21;
   // Only meaningful on the normal path, where 0 <= e <= 30 keeps |e-21| within 21.
   assign shiftCount  = eMinus21[10] ? eMinus21Neg[4:0] : eMinus21[4:0];
   assign satValue    = opSign ? 32'h8000_0000 : 32'h7FFF_FFFF;

   always_ff @(posedge clock_100Khz or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         sticky_q <= 1'b0;
         int_q    <= '0;
         status_q <= ST_EXACT;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         sticky_q <= sticky_d;
         int_q    <= int_d;
         status_q <= status_d;
      end
   end

   // Results are written into int_q/status_q only on the edge that enters DONE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      sticky_d = sticky_q;
      int_d    = int_q;
      status_d = status_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op_in;
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = DONE;
            if (opExp == 10'd0) begin
               int_d    = '0;
               status_d = ST_EXACT;
            end else if (opExp == 10'h3FF) begin
               int_d    = satValue;
               status_d = ST_OVERFLOW;
            end else if (e[10]) begin
               int_d    = '0;
               status_d = ST_UNDERFLOW;
            end else if (opSign && (e == 11'sd31) && (opMant == 21'd0)) begin
               int_d    = 32'h8000_0000;
               status_d = ST_EXACT;
            end else if (e >= 11'sd31) begin
               int_d    = satValue;
               status_d = ST_OVERFLOW;
            end else begin
               acc_d    = {10'd0, 1'b1, opMant};
               sticky_d = 1'b0;
               cnt_d    = shiftCount;
               left_d   = ~eMinus21[10];
               state_d  = (shiftCount != 5'd0) ? SHIFT : SIGN;
            end
         end
         SHIFT: begin
            if (left_q) begin
               acc_d = {acc_q[30:0], 1'b0};
            end else begin
               acc_d    = {1'b0, acc_q[31:1]};
               sticky_d = sticky_q | acc_q[0];
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            int_d    = opSign ? (32'd0 - acc_q) : acc_q;
            status_d = sticky_q ? ST_INEXACT : ST_EXACT;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign int_out    = int_q;
   assign status_out = status_q;

endmodule
